// File: rtl/mix_columns_seq_if.sv
// Handshake bundle between the row-shift stage, the column-serial
// MixColumns stage and AddRoundKey. The slave modport is the MixColumns side.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] instate;
  logic         in_final;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] outstate;

  modport slave (
    input  in_valid, instate, in_final, out_ready,
    output in_ready, out_valid, outstate
  );

  modport master (
    output in_valid, instate, in_final, out_ready,
    input  in_ready, out_valid, outstate
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns. A captured 128-bit state is pushed through
// COLS_PER_CYCLE column lanes per clock; the final-round flag turns every lane
// into a wire so the bypass path keeps exactly the same latency.

// One 32-bit column through the FIPS-197 MixColumns matrix (or straight through).
module mix_columns_lane (
  input  logic [31:0] col_i,
  input  logic        bypass_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  // Row 0 sits in the most significant byte of the column.
  assign {a0, a1, a2, a3} = col_i;

  // Matrix rows {2,3,1,1} rotated; 3x is written as xtime(x)^x.
  always_comb begin
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign col_o = bypass_i ? col_i : {b0, b1, b2, b3};
endmodule

module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  mix_columns_seq_if.slave io
);
  // Lane count must evenly divide the four columns.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter advances by the lane count; LAST is the base column of the
  // final group, so the counter never climbs past 3.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic         final_q, final_d;
  logic [127:0] outstate_q, outstate_d;
  logic         out_valid_q, out_valid_d;

  logic         in_ready;
  logic         accept;

  logic [COLS_PER_CYCLE-1:0][31:0] lane_in;
  logic [COLS_PER_CYCLE-1:0][31:0] lane_out;

  // A new block can enter when idle, or when the finished block leaves on the same edge.
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & io.out_ready);
  assign accept   = io.in_valid & in_ready;

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.outstate  = outstate_q;

  // Gather the current group of columns; column c lives at bit base (3-c)*32.
  always_comb begin
    lane_in = '0;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      logic [1:0] col;
      col        = cnt_q + 2'(i);
      lane_in[i] = work_q[{~col, 5'd0} +: 32];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    mix_columns_lane u_lane (
      .col_i    (lane_in[g]),
      .bypass_i (final_q),
      .col_o    (lane_out[g])
    );
  end

  // Next-state: walk the columns in BUSY, hold in DONE, capture on accept.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    final_d     = final_q;
    outstate_d  = outstate_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: ;
      BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          logic [1:0] col;
          col                              = cnt_q + 2'(i);
          outstate_d[{~col, 5'd0} +: 32]   = lane_out[i];
        end
        if (cnt_q == LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          cnt_d       = 2'd0;
        end else begin
          cnt_d = cnt_q + STEP;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept overrides the DONE->IDLE release so back-to-back blocks see no bubble.
    if (accept) begin
      work_d  = io.instate;
      final_d = io.in_final;
      cnt_d   = 2'd0;
      state_d = BUSY;
    end
  end

  // State registers; reset drops any in-flight block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      work_q      <= '0;
      final_q     <= 1'b0;
      outstate_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      final_q     <= final_d;
      outstate_q  <= outstate_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2 and 4 columns per cycle)
// share one stimulus; each has a scoreboard fed by a GF(2^8) matrix model.
module tb_mix_columns_seq;
  localparam int ND = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_final = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] instate = '0;

  logic         ov [ND];
  logic         ir [ND];
  logic [127:0] os [ND];
  int           nl [ND];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: textbook MixColumns as a matrix product over GF(2^8).
  localparam int MX [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [8:0] x;
    p = '0;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic fin);
    logic [127:0] o;
    logic [7:0]   acc;
    if (fin) return s;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127 - 32*c - 8*k -: 8], 8'(MX[r][k]));
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    return o;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int C    = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int NLAT = 4 / C;

    mix_columns_seq_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.instate   = instate;
    assign bus.in_final  = in_final;
    assign bus.out_ready = out_ready;
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign os[g] = bus.outstate;
    assign nl[g] = NLAT;

    mix_columns_seq #(.COLS_PER_CYCLE(C)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .io      (bus)
    );

    logic [127:0] exp_q [$];
    int           acc_q [$];
    logic         ov_p = 1'b0;
    logic         or_p = 1'b0;
    logic [127:0] os_p = '0;

    // Scoreboard, sampled mid-cycle: results, latency, hold-while-stalled, reset state.
    always @(negedge clk) begin
      if (!reset_n) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.outstate !== '0) begin
          errors++;
          $display("FAIL reset_state dut%0d out_valid=%b outstate=%h want 0/0", g, bus.out_valid, bus.outstate);
        end
        exp_q.delete();
        acc_q.delete();
        ov_p <= 1'b0;
        or_p <= 1'b0;
      end else begin
        if (ov_p && !or_p) begin
          checks++;
          if (bus.out_valid !== 1'b1 || bus.outstate !== os_p) begin
            errors++;
            $display("FAIL hold dut%0d out_valid=%b outstate=%h want 1/%h", g, bus.out_valid, bus.outstate, os_p);
          end
        end
        if (bus.out_valid && !ov_p) begin
          checks++;
          if (acc_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_valid dut%0d got out_valid=1 want 0", g);
          end else if (cyc - acc_q[0] != NLAT) begin
            errors++;
            $display("FAIL latency dut%0d got %0d edges want %0d", g, cyc - acc_q[0], NLAT);
          end
        end
        if (bus.out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected dut%0d got %h want none", g, bus.outstate);
          end else begin
            if (bus.outstate !== exp_q[0]) begin
              errors++;
              $display("FAIL result dut%0d got %h want %h", g, bus.outstate, exp_q[0]);
            end
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
        if (in_valid && bus.in_ready) begin
          exp_q.push_back(mix(instate, in_final));
          acc_q.push_back(cyc + 1);
        end
        ov_p <= bus.out_valid;
        or_p <= out_ready;
        os_p <= bus.outstate;
      end
    end
  end

  typedef struct {
    logic [127:0] din;
    logic         fin;
    logic [127:0] dexp;
  } vec_t;

  vec_t tbl [4];

  task automatic check_eq(input string name, input int k, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, k, got, want);
    end
  endtask

  task automatic wait_all_ready();
    int t;
    t = 0;
    while (!(ir[0] && ir[1] && ir[2]) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL ready_timeout got in_ready=%b%b%b want 111", ir[0], ir[1], ir[2]);
    end
  endtask

  // Inputs already presented with in_valid=1; take the accept edge, then
  // scramble the inputs and time every instance's result.
  task automatic finish_vec(input vec_t v);
    int first [ND];
    @(posedge clk); #1;
    in_valid = 1'b0;
    instate  = {$urandom, $urandom, $urandom, $urandom};
    in_final = ~v.fin;
    for (int k = 0; k < ND; k++) first[k] = -1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++)
        if (ov[k] && first[k] < 0) begin
          first[k] = e;
          check_eq("vec_result", k, os[k], v.dexp);
        end
    end
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (first[k] != nl[k]) begin
        errors++;
        $display("FAIL vec_latency dut%0d got %0d edges want %0d", k, first[k], nl[k]);
      end
      check_eq("ready_after", k, 128'(ir[k]), 128'd1);
    end
  endtask

  task automatic run_vec(input vec_t v);
    wait_all_ready();
    in_valid  = 1'b1;
    instate   = v.din;
    in_final  = v.fin;
    out_ready = 1'b1;
    finish_vec(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [ND];

    tbl[0] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
    tbl[1] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    tbl[2] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    tbl[3] = '{128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6};

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      check_eq("rst_valid", k, 128'(ov[k]), 128'd0);
      check_eq("rst_outstate", k, os[k], 128'd0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < ND; k++) check_eq("rst_ready", k, 128'(ir[k]), 128'd1);

    // Known-answer vectors, including final-round bypass.
    for (int i = 0; i < 3; i++) run_vec(tbl[i]);

    // Completed block stalled by downstream, then release + accept on one edge.
    wait_all_ready();
    in_valid = 1'b1; instate = tbl[1].din; in_final = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      instate  = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < ND; k++) begin
        check_eq("stall_valid", k, 128'(ov[k]), 128'd1);
        check_eq("stall_data", k, os[k], tbl[1].dexp);
        check_eq("stall_ready", k, 128'(ir[k]), 128'd0);
      end
      @(posedge clk); #1;
    end
    instate = tbl[3].din; in_final = 1'b0; out_ready = 1'b1;
    #1;
    for (int k = 0; k < ND; k++) check_eq("release_ready", k, 128'(ir[k]), 128'd1);
    finish_vec(tbl[3]);

    // Back-to-back streaming: one result every N+1 cycles per instance.
    for (int k = 0; k < ND; k++) cnt[k] = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      instate  = {$urandom, $urandom, $urandom, $urandom};
      in_final = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) if (ov[k]) cnt[k]++;
    end
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (cnt[k] != 60 / (nl[k] + 1)) begin
        errors++;
        $display("FAIL throughput dut%0d got %0d results want %0d", k, cnt[k], 60 / (nl[k] + 1));
      end
    end

    // Random traffic with random downstream stalls.
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      instate   = {$urandom, $urandom, $urandom, $urandom};
      in_final  = ($urandom_range(0, 4) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Reset two cycles into a block: nothing from it may ever appear.
    wait_all_ready();
    in_valid = 1'b1; instate = tbl[0].din; in_final = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      check_eq("midrst_valid", k, 128'(ov[k]), 128'd0);
      check_eq("midrst_outstate", k, os[k], 128'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) check_eq("no_stale", k, 128'(ov[k]), 128'd0);
    end
    run_vec(tbl[1]);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
